// File: rtl/router_pkg.sv
// Shared router constants: data width default and header address field layout,
// common to the control FSM, this register stage and the output FIFOs.
package router_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned ADDR_LSB   = 0;

    localparam logic [ADDR_W-1:0] ADDR_P0 = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_P1 = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_P2 = 2'b10;

    // Destination address carried in the header byte.
    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W_DEF-1:0] hdr);
        return hdr[ADDR_LSB +: ADDR_W];
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Even-parity accumulator and checker for one packet. Folds header and payload
// bytes into int_parity, captures the trailing parity byte, and flags a mismatch.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] header_i,
    input  logic              pkt_valid_i,
    input  logic              fifo_full_i,
    input  logic              detect_add_i,
    input  logic              lfd_state_i,
    input  logic              ld_state_i,
    input  logic              laf_state_i,
    input  logic              full_state_i,
    input  logic              low_packet_valid_i,
    output logic              parity_done_o,
    output logic              err_o
);

    logic [DATA_W-1:0] int_parity_q, int_parity_d;
    logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;
    logic              parity_done_q, parity_done_d;
    logic              err_q, err_d;
    logic              pkt_load;

    // Next-state for parity accumulation, parity-byte capture and error flag.
    always_comb begin
        // Parity byte arrives either straight through in ld_state, or replayed after a full stall.
        pkt_load = (ld_state_i && !fifo_full_i && !pkt_valid_i) ||
                   (laf_state_i && low_packet_valid_i && !parity_done_q);

        int_parity_d = int_parity_q;
        if (detect_add_i) begin
            int_parity_d = '0;
        end else if (lfd_state_i) begin
            int_parity_d = int_parity_q ^ header_i;
        end else if (ld_state_i && pkt_valid_i && !full_state_i) begin
            int_parity_d = int_parity_q ^ data_i;
        end

        pkt_parity_d = pkt_load ? data_i : pkt_parity_q;

        parity_done_d = parity_done_q;
        if (detect_add_i) begin
            parity_done_d = 1'b0;
        end else if (pkt_load) begin
            parity_done_d = 1'b1;
        end

        err_d = err_q;
        if (detect_add_i) begin
            err_d = 1'b0;
        end else if (parity_done_q) begin
            err_d = (int_parity_q != pkt_parity_q);
        end
    end

    // Parity state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            int_parity_q  <= '0;
            pkt_parity_q  <= '0;
            parity_done_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            int_parity_q  <= int_parity_d;
            pkt_parity_q  <= pkt_parity_d;
            parity_done_q <= parity_done_d;
            err_q         <= err_d;
        end
    end

    assign parity_done_o = parity_done_q;
    assign err_o         = err_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header/full-byte holding, output byte mux and
// packet status. Optional error counter enabled by defining ROUTER_REG_ERR_CNT_EN.
module router_reg
    import router_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic              err
);

    logic [DATA_W-1:0] header_q, header_d;
    logic [DATA_W-1:0] full_byte_q, full_byte_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              lpv_q, lpv_d;

    // Next-state for header, stalled byte, output byte and low_packet_valid.
    always_comb begin
        header_d = (detect_add && pkt_valid) ? data_in : header_q;

        // Byte presented while the FIFO filled; replayed in laf_state.
        full_byte_d = (ld_state && fifo_full) ? data_in : full_byte_q;

        dout_d = dout_q;
        if (lfd_state) begin
            dout_d = header_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (laf_state) begin
            dout_d = full_byte_q;
        end

        lpv_d = lpv_q;
        if (rst_int_reg) begin
            lpv_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            lpv_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_q    <= '0;
            full_byte_q <= '0;
            dout_q      <= '0;
            lpv_q       <= 1'b0;
        end else begin
            header_q    <= header_d;
            full_byte_q <= full_byte_d;
            dout_q      <= dout_d;
            lpv_q       <= lpv_d;
        end
    end

    router_parity_chk #(
        .DATA_W (DATA_W)
    ) u_parity_chk (
        .clk_i              (clock),
        .rst_ni             (resetn),
        .data_i             (data_in),
        .header_i           (header_q),
        .pkt_valid_i        (pkt_valid),
        .fifo_full_i        (fifo_full),
        .detect_add_i       (detect_add),
        .lfd_state_i        (lfd_state),
        .ld_state_i         (ld_state),
        .laf_state_i        (laf_state),
        .full_state_i       (full_state),
        .low_packet_valid_i (lpv_q),
        .parity_done_o      (parity_done),
        .err_o              (err)
    );

    assign dout             = dout_q;
    assign low_packet_valid = lpv_q;

`ifdef ROUTER_REG_ERR_CNT_EN
    logic       err_prev_q;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count rising edges of err, saturating.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err && !err_prev_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_prev_q <= 1'b0;
            err_cnt_q  <= 8'h00;
        end else begin
            err_prev_q <= err;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Directed, table-driven bench for router_reg. Build with ROUTER_REG_ERR_CNT_EN
// defined to also exercise the error counter.
module tb_router_reg;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_packet_valid;
    logic       err;
`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks;
    int n_fail;

    router_reg #(
        .DATA_W (8)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
`ifdef ROUTER_REG_ERR_CNT_EN
        .err_cnt          (err_cnt),
`endif
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        bit         da, lfd, ld, laf, fs, rir, pv, ff;
        logic [7:0] d;
        logic [7:0] e_dout;
        bit         e_pd, e_lpv, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input string n, input bit da, input bit lfd, input bit ld,
                               input bit laf, input bit fs, input bit rir, input bit pv,
                               input bit ff, input logic [7:0] d, input logic [7:0] ed,
                               input bit epd, input bit elpv, input bit eerr);
        vec_t r;
        r.name = n; r.da = da; r.lfd = lfd; r.ld = ld; r.laf = laf; r.fs = fs;
        r.rir = rir; r.pv = pv; r.ff = ff; r.d = d; r.e_dout = ed;
        r.e_pd = epd; r.e_lpv = elpv; r.e_err = eerr;
        return r;
    endfunction

    task automatic check(input string n, input string what, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", n, what, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        detect_add  = t.da;
        lfd_state   = t.lfd;
        ld_state    = t.ld;
        laf_state   = t.laf;
        full_state  = t.fs;
        rst_int_reg = t.rir;
        pkt_valid   = t.pv;
        fifo_full   = t.ff;
        data_in     = t.d;
        @(posedge clock);
        #1;
    endtask

    task automatic apply(input vec_t t);
        drive(t);
        check(t.name, "dout", dout, t.e_dout);
        check(t.name, "parity_done", {7'd0, parity_done}, {7'd0, t.e_pd});
        check(t.name, "low_packet_valid", {7'd0, low_packet_valid}, {7'd0, t.e_lpv});
        check(t.name, "err", {7'd0, err}, {7'd0, t.e_err});
    endtask

`ifdef ROUTER_REG_ERR_CNT_EN
    // Header 05, payload A3, wrong parity A7, then two idle cycles.
    task automatic bad_pkt();
        drive(v("bp", 1, 0, 0, 0, 0, 0, 1, 0, 8'h05, 0, 0, 0, 0));
        drive(v("bp", 0, 1, 0, 0, 0, 0, 1, 0, 8'hA3, 0, 0, 0, 0));
        drive(v("bp", 0, 0, 1, 0, 0, 0, 1, 0, 8'hA3, 0, 0, 0, 0));
        drive(v("bp", 0, 0, 1, 0, 0, 0, 0, 0, 8'hA7, 0, 0, 0, 0));
        drive(v("bp", 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        drive(v("bp", 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn = 1'b0;
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = '0;
        pkt_valid = 1'b0;
        fifo_full = 1'b0;
        data_in   = 8'h00;

        //             name         da lfd ld laf fs rir pv ff data    dout  pd lpv err
        // Good packet: hdr 05, payload A3, parity A6.
        vecs.push_back(v("g_da",    1, 0, 0, 0, 0, 0, 1, 0, 8'h05, 8'h00, 0, 0, 0));
        vecs.push_back(v("g_lfd",   0, 1, 0, 0, 0, 0, 1, 0, 8'hA3, 8'h05, 0, 0, 0));
        vecs.push_back(v("g_ld",    0, 0, 1, 0, 0, 0, 1, 0, 8'hA3, 8'hA3, 0, 0, 0));
        vecs.push_back(v("g_par",   0, 0, 1, 0, 0, 0, 0, 0, 8'hA6, 8'hA6, 1, 1, 0));
        vecs.push_back(v("g_chk",   0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hA6, 1, 1, 0));
        vecs.push_back(v("g_rir",   0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'hA6, 1, 0, 0));
        // Bad packet: parity A7.
        vecs.push_back(v("b_da",    1, 0, 0, 0, 0, 0, 1, 0, 8'h05, 8'hA6, 0, 0, 0));
        vecs.push_back(v("b_lfd",   0, 1, 0, 0, 0, 0, 1, 0, 8'hA3, 8'h05, 0, 0, 0));
        vecs.push_back(v("b_ld",    0, 0, 1, 0, 0, 0, 1, 0, 8'hA3, 8'hA3, 0, 0, 0));
        vecs.push_back(v("b_par",   0, 0, 1, 0, 0, 0, 0, 0, 8'hA7, 8'hA7, 1, 1, 0));
        vecs.push_back(v("b_chk",   0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hA7, 1, 1, 1));
        vecs.push_back(v("b_rir",   0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'hA7, 1, 0, 1));
        // FIFO fills as 3C arrives; full_state cycle must not touch parity.
        vecs.push_back(v("f_da",    1, 0, 0, 0, 0, 0, 1, 0, 8'h06, 8'hA7, 0, 0, 0));
        vecs.push_back(v("f_lfd",   0, 1, 0, 0, 0, 0, 1, 0, 8'h3C, 8'h06, 0, 0, 0));
        vecs.push_back(v("f_ldful", 0, 0, 1, 0, 0, 0, 1, 1, 8'h3C, 8'h06, 0, 0, 0));
        vecs.push_back(v("f_full",  0, 0, 0, 0, 1, 0, 1, 1, 8'h3C, 8'h06, 0, 0, 0));
        vecs.push_back(v("f_laf",   0, 0, 0, 1, 0, 0, 1, 0, 8'h3C, 8'h3C, 0, 0, 0));
        vecs.push_back(v("f_par",   0, 0, 1, 0, 0, 0, 0, 0, 8'h3A, 8'h3A, 1, 1, 0));
        vecs.push_back(v("f_chk",   0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h3A, 1, 1, 0));
        vecs.push_back(v("f_rir",   0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h3A, 1, 0, 0));
        // Parity byte arrives as FIFO fills; captured from laf_state.
        vecs.push_back(v("l_da",    1, 0, 0, 0, 0, 0, 1, 0, 8'h09, 8'h3A, 0, 0, 0));
        vecs.push_back(v("l_lfd",   0, 1, 0, 0, 0, 0, 1, 0, 8'h11, 8'h09, 0, 0, 0));
        vecs.push_back(v("l_ld",    0, 0, 1, 0, 0, 0, 1, 0, 8'h11, 8'h11, 0, 0, 0));
        vecs.push_back(v("l_ldful", 0, 0, 1, 0, 0, 0, 0, 1, 8'h18, 8'h11, 0, 1, 0));
        vecs.push_back(v("l_full",  0, 0, 0, 0, 1, 0, 0, 1, 8'h18, 8'h11, 0, 1, 0));
        vecs.push_back(v("l_laf",   0, 0, 0, 1, 0, 0, 0, 0, 8'h18, 8'h18, 1, 1, 0));
        vecs.push_back(v("l_chk",   0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h18, 1, 1, 0));
        vecs.push_back(v("l_rir",   0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h18, 1, 0, 0));
        // detect_add with lfd: dout takes the old header, status clears.
        vecs.push_back(v("p_both",  1, 1, 0, 0, 0, 0, 1, 0, 8'h22, 8'h09, 0, 0, 0));
        vecs.push_back(v("p_lfd",   0, 1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h22, 0, 0, 0));

        #12;
        check("reset", "dout", dout, 8'h00);
        check("reset", "parity_done", {7'd0, parity_done}, 8'h00);
        check("reset", "low_packet_valid", {7'd0, low_packet_valid}, 8'h00);
        check("reset", "err", {7'd0, err}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Bad packet then asynchronous reset with err and parity_done high.
        apply(v("r_da",  1, 0, 0, 0, 0, 0, 1, 0, 8'h05, 8'h22, 0, 0, 0));
        apply(v("r_lfd", 0, 1, 0, 0, 0, 0, 1, 0, 8'hA3, 8'h05, 0, 0, 0));
        apply(v("r_ld",  0, 0, 1, 0, 0, 0, 1, 0, 8'hA3, 8'hA3, 0, 0, 0));
        apply(v("r_par", 0, 0, 1, 0, 0, 0, 0, 0, 8'hA7, 8'hA7, 1, 1, 0));
        apply(v("r_chk", 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hA7, 1, 1, 1));
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst", "dout", dout, 8'h00);
        check("async_rst", "parity_done", {7'd0, parity_done}, 8'h00);
        check("async_rst", "low_packet_valid", {7'd0, low_packet_valid}, 8'h00);
        check("async_rst", "err", {7'd0, err}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        // No detect_add: relies on header and int_parity having been cleared.
        apply(v("c_lfd", 0, 1, 0, 0, 0, 0, 1, 0, 8'hA3, 8'h00, 0, 0, 0));
        apply(v("c_ld",  0, 0, 1, 0, 0, 0, 1, 0, 8'hA3, 8'hA3, 0, 0, 0));
        apply(v("c_par", 0, 0, 1, 0, 0, 0, 0, 0, 8'hA3, 8'hA3, 1, 1, 0));
        apply(v("c_chk", 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hA3, 1, 1, 0));

`ifdef ROUTER_REG_ERR_CNT_EN
        resetn = 1'b0;
        #1;
        check("cnt_rst", "err_cnt", err_cnt, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) bad_pkt();
        check("cnt_3", "err_cnt", err_cnt, 8'd3);
        for (int i = 0; i < 257; i++) bad_pkt();
        check("cnt_sat", "err_cnt", err_cnt, 8'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
